// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: owns the PC, issues in-order memory requests, and buffers
// returned instructions with their PCs for decode. Handles redirect flush and stall.
module fetch_queue_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 4,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    input  logic            id_ready,
    output logic [XLEN-1:0] fetch_pc
);

    localparam int CW = $clog2(QDEPTH) + 1;
    localparam int PW = $clog2(QDEPTH);

    logic [XLEN-1:0] pcReg;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;

    logic [XLEN-1:0] qPc    [QDEPTH];
    logic [XLEN-1:0] qInstr [QDEPTH];
    logic [XLEN-1:0] tagPc  [QDEPTH];
    logic [PW-1:0]   qRd;
    logic [PW-1:0]   qWr;
    logic [PW-1:0]   tagRd;
    logic [PW-1:0]   tagWr;

    logic [CW:0]     inUse;
    logic            keepRsp;
    logic            popHead;

    // Credits cover both queued entries and requests still in flight, so a kept
    // response always finds a free queue slot.
    assign inUse    = {1'b0, outstanding} + {1'b0, count};
    assign imem_req = reset && !stall && !redirect && (inUse < (CW+1)'(QDEPTH));
    assign imem_addr = pcReg;
    assign fetch_pc  = pcReg;

    assign keepRsp  = imem_rvalid && (discard == '0) && !redirect;
    assign popHead  = id_valid && id_ready && !redirect;

    assign id_valid = (count != '0);
    assign id_instr = id_valid ? qInstr[qRd] : '0;
    assign id_pc    = id_valid ? qPc[qRd]    : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcReg       <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            qRd         <= '0;
            qWr         <= '0;
            tagRd       <= '0;
            tagWr       <= '0;
        end else begin
            if (redirect)
                pcReg <= redirect_pc;
            else if (imem_req)
                pcReg <= pcReg + XLEN'(PC_STEP);

            if (imem_req)
                tagWr <= tagWr + PW'(1);
            if (imem_rvalid)
                tagRd <= tagRd + PW'(1);

            outstanding <= outstanding + CW'(imem_req) - CW'(imem_rvalid);

            // Everything still in flight after this edge belongs to the old path.
            if (redirect)
                discard <= outstanding - CW'(imem_rvalid);
            else if (imem_rvalid && (discard != '0))
                discard <= discard - CW'(1);

            if (redirect) begin
                count <= '0;
                qRd   <= qWr;
            end else begin
                count <= count + CW'(keepRsp) - CW'(popHead);
                if (popHead)
                    qRd <= qRd + PW'(1);
                if (keepRsp)
                    qWr <= qWr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (imem_req)
            tagPc[tagWr] <= pcReg;
        if (keepRsp) begin
            qPc[qWr]    <= tagPc[tagRd];
            qInstr[qWr] <= imem_rdata;
        end
    end

    keptRspHasRoom: assert property (@(posedge clk) disable iff (!reset)
        keepRsp |-> (count < CW'(QDEPTH)));

    rspWasRequested: assert property (@(posedge clk) disable iff (!reset)
        imem_rvalid |-> (outstanding != '0));

endmodule
